// File: rtl/dyn_comp_sequencer.sv
// ---------------------------------------------------------------------------
// dyn_comp_sequencer
//
// Purpose:
//   Generates the clock for a dynamic comparator and collects its decisions.
//   Each decision is one precharge phase (comp_clk low) followed by one
//   evaluate phase (comp_clk high). The phase lengths are programmable.
//   The raw comparator output is passed through a synchronizer. It is
//   sampled on the last evaluate cycle of each decision and added to a
//   ones-count. A burst ends after a programmed number of decisions.
//
// Ports:
//   wb_clk_i       in   system clock
//   wb_rst_i       in   asynchronous active-high reset
//   start          in   single-cycle pulse, begins a burst (IDLE only)
//   abort          in   level, forces IDLE; highest priority
//   continuous     in   re-arm a fresh burst after result_ack
//   prech_cycles   in   precharge length in clocks (latched at start)
//   eval_cycles    in   evaluate length in clocks (latched at start)
//   num_samples    in   decisions per burst (latched at start)
//   comp_out       in   raw comparator decision, asynchronous
//   comp_clk       out  comparator clock, 0 = precharge, 1 = evaluate
//   busy           out  high in PRECH, EVAL or DONE
//   result_valid   out  high in DONE
//   result_ack     in   consumes the result (DONE only)
//   ones_count     out  decisions equal to 1 in the last/current burst
//   last_decision  out  most recent sampled decision
// ---------------------------------------------------------------------------
module dyn_comp_sequencer #(
  parameter int CNT_W       = 16,
  parameter int PH_W        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [PH_W-1:0]  prech_cycles,
  input  logic [PH_W-1:0]  eval_cycles,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             comp_out,
  output logic             comp_clk,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [CNT_W-1:0] ones_count,
  output logic             last_decision
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRECH = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The evaluate phase must be long enough for a decision that resolves at
  // the rising edge of comp_clk to reach the end of the synchronizer.
  localparam logic [PH_W-1:0]  EVAL_MIN = PH_W'(SYNC_STAGES + 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // -------------------------------------------------------------------------
  // comp_out synchronizer
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_reg <= '0;
    end else if (SYNC_STAGES == 1) begin
      sync_reg <= SYNC_STAGES'(comp_out);
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], comp_out};
    end
  end

  assign sync_q = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Clamped configuration, computed from the live inputs. It is used only
  // at the moment a start is accepted.
  // -------------------------------------------------------------------------
  logic [PH_W-1:0]  pe_next;
  logic [PH_W-1:0]  ee_next;
  logic [CNT_W-1:0] ne_next;

  always_comb begin
    pe_next = prech_cycles;
    ee_next = eval_cycles;
    ne_next = num_samples;
    if (prech_cycles == '0) begin
      pe_next = PH_ONE;
    end
    if (eval_cycles < EVAL_MIN) begin
      ee_next = EVAL_MIN;
    end
    if (num_samples == '0) begin
      ne_next = CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  state_t           state_reg;
  logic [PH_W-1:0]  pe_reg;
  logic [PH_W-1:0]  ee_reg;
  logic [CNT_W-1:0] ne_reg;
  logic [PH_W-1:0]  phase_cnt_reg;
  logic [CNT_W-1:0] sample_cnt_reg;
  logic [CNT_W-1:0] ones_count_reg;
  logic             last_decision_reg;
  logic             comp_clk_reg;
  logic             busy_reg;
  logic             result_valid_reg;

  logic             prech_last;
  logic             eval_last;
  logic [CNT_W-1:0] sample_inc;

  // Both phase counters run from 0 up to length-1. The latched lengths are
  // always at least 1, so the subtraction cannot wrap.
  assign prech_last = (phase_cnt_reg == (pe_reg - PH_ONE));
  assign eval_last  = (phase_cnt_reg == (ee_reg - PH_ONE));
  assign sample_inc = sample_cnt_reg + CNT_ONE;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg         <= S_IDLE;
      pe_reg            <= '0;
      ee_reg            <= '0;
      ne_reg            <= '0;
      phase_cnt_reg     <= '0;
      sample_cnt_reg    <= '0;
      ones_count_reg    <= '0;
      last_decision_reg <= 1'b0;
      comp_clk_reg      <= 1'b0;
      busy_reg          <= 1'b0;
      result_valid_reg  <= 1'b0;
    end else if (abort) begin
      // The partial ones_count and last_decision are kept so that software
      // can inspect them after an abort.
      state_reg        <= S_IDLE;
      phase_cnt_reg    <= '0;
      comp_clk_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          comp_clk_reg <= 1'b0;
          if (start) begin
            pe_reg         <= pe_next;
            ee_reg         <= ee_next;
            ne_reg         <= ne_next;
            phase_cnt_reg  <= '0;
            sample_cnt_reg <= '0;
            ones_count_reg <= '0;
            busy_reg       <= 1'b1;
            state_reg      <= S_PRECH;
          end
        end

        S_PRECH: begin
          if (prech_last) begin
            phase_cnt_reg <= '0;
            comp_clk_reg  <= 1'b1;
            state_reg     <= S_EVAL;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + PH_ONE;
          end
        end

        S_EVAL: begin
          if (eval_last) begin
            // The decision is captured on the same edge that drops comp_clk.
            // The synchronized value then reflects the comparator state
            // from well inside the evaluate window.
            phase_cnt_reg     <= '0;
            comp_clk_reg      <= 1'b0;
            ones_count_reg    <= ones_count_reg + CNT_W'(sync_q);
            last_decision_reg <= sync_q;
            sample_cnt_reg    <= sample_inc;
            if (sample_inc == ne_reg) begin
              result_valid_reg <= 1'b1;
              state_reg        <= S_DONE;
            end else begin
              state_reg <= S_PRECH;
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg + PH_ONE;
          end
        end

        S_DONE: begin
          comp_clk_reg <= 1'b0;
          if (result_ack) begin
            result_valid_reg <= 1'b0;
            if (continuous) begin
              // A new burst reuses the configuration latched at the last
              // start. Only the result accumulators are restarted.
              phase_cnt_reg  <= '0;
              sample_cnt_reg <= '0;
              ones_count_reg <= '0;
              state_reg      <= S_PRECH;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end
          end
        end

        default: begin
          comp_clk_reg     <= 1'b0;
          busy_reg         <= 1'b0;
          result_valid_reg <= 1'b0;
          state_reg        <= S_IDLE;
        end
      endcase
    end
  end

  assign comp_clk      = comp_clk_reg;
  assign busy          = busy_reg;
  assign result_valid  = result_valid_reg;
  assign ones_count    = ones_count_reg;
  assign last_decision = last_decision_reg;

endmodule

// File: tb/tb_dyn_comp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dyn_comp_sequencer
//
// Directed bench for dyn_comp_sequencer. A table of burst vectors gives the
// configuration, the per-decision comp_out pattern and the expected results.
// These vectors are followed by hand-written sequences for continuous mode,
// abort and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_dyn_comp_sequencer;

  localparam int CNT_W = 16;
  localparam int PH_W  = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             continuous;
  logic [PH_W-1:0]  prech_cycles;
  logic [PH_W-1:0]  eval_cycles;
  logic [CNT_W-1:0] num_samples;
  logic             comp_out;
  logic             comp_clk;
  logic             busy;
  logic             result_valid;
  logic             result_ack;
  logic [CNT_W-1:0] ones_count;
  logic             last_decision;

  dyn_comp_sequencer #(
    .CNT_W(CNT_W),
    .PH_W(PH_W),
    .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .start(start),
    .abort(abort),
    .continuous(continuous),
    .prech_cycles(prech_cycles),
    .eval_cycles(eval_cycles),
    .num_samples(num_samples),
    .comp_out(comp_out),
    .comp_clk(comp_clk),
    .busy(busy),
    .result_valid(result_valid),
    .result_ack(result_ack),
    .ones_count(ones_count),
    .last_decision(last_decision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PH_W-1:0]  prech;
    logic [PH_W-1:0]  eval;
    logic [CNT_W-1:0] ns;
    logic [31:0]      pat;     // bit d = comp_out during decision d
    int               pe;      // expected clamped precharge length
    int               ee;      // expected clamped evaluate length
    int               cycles;  // expected start edge -> result_valid
    logic [CNT_W-1:0] ones;
    logic             last;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Steps through ncyc cycles of a running burst, starting just after the
  // edge that began it. It drives comp_out per decision and counts cycles
  // where comp_clk, busy or result_valid deviate. When start_at >= 0, it
  // pulses start with a different config at that cycle, which the DUT must
  // ignore.
  task automatic run_phases(input int pe, input int ee, input int ncyc,
                            input logic [31:0] pat, input int start_at,
                            output int errs);
    logic exp_clk;
    errs = 0;
    for (int k = 0; k < ncyc; k++) begin
      comp_out = pat[k / (pe + ee)];
      exp_clk  = ((k % (pe + ee)) >= pe);
      if (comp_clk !== exp_clk || busy !== 1'b1 || result_valid !== 1'b0) begin
        errs++;
      end
      if (k == start_at) begin
        start        = 1'b1;
        prech_cycles = 8'd7;
        eval_cycles  = 8'd9;
        num_samples  = 16'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic run_vector(input int i);
    int errs;
    prech_cycles = vecs[i].prech;
    eval_cycles  = vecs[i].eval;
    num_samples  = vecs[i].ns;
    start        = 1'b1;
    tick();
    start = 1'b0;
    run_phases(vecs[i].pe, vecs[i].ee, vecs[i].cycles, vecs[i].pat, -1, errs);
    check($sformatf("v%0d_pattern_errs", i), errs, 0);
    check($sformatf("v%0d_result_valid", i), result_valid, 1);
    check($sformatf("v%0d_ones_count", i), ones_count, vecs[i].ones);
    check($sformatf("v%0d_last_decision", i), last_decision, vecs[i].last);
    check($sformatf("v%0d_comp_clk_done", i), comp_clk, 0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check($sformatf("v%0d_busy_after_ack", i), busy, 0);
    check($sformatf("v%0d_rv_after_ack", i), result_valid, 0);
    $display("vector %0d: prech=%0d eval=%0d ns=%0d -> ones=%0d last=%0d",
             i, vecs[i].prech, vecs[i].eval, vecs[i].ns, ones_count, last_decision);
  endtask

  initial begin
    int errs;

    vecs[0] = '{prech: 8'd2, eval: 8'd4, ns: 16'd3, pat: 32'hFFFF_FFFF,
                pe: 2, ee: 4, cycles: 18, ones: 16'd3, last: 1'b1};
    vecs[1] = '{prech: 8'd0, eval: 8'd1, ns: 16'd0, pat: 32'hFFFF_FFFF,
                pe: 1, ee: 3, cycles: 4, ones: 16'd1, last: 1'b1};
    vecs[2] = '{prech: 8'd3, eval: 8'd3, ns: 16'd8, pat: 32'hAAAA_AAAA,
                pe: 3, ee: 3, cycles: 48, ones: 16'd4, last: 1'b1};
    vecs[3] = '{prech: 8'd1, eval: 8'd5, ns: 16'd4, pat: 32'h0000_0000,
                pe: 1, ee: 5, cycles: 24, ones: 16'd0, last: 1'b0};
    vecs[4] = '{prech: 8'd4, eval: 8'd3, ns: 16'd3, pat: 32'h0000_0005,
                pe: 4, ee: 3, cycles: 21, ones: 16'd2, last: 1'b1};

    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    continuous   = 1'b0;
    result_ack   = 1'b0;
    comp_out     = 1'b0;
    prech_cycles = '0;
    eval_cycles  = '0;
    num_samples  = '0;

    // Reset state
    tick();
    check("rst_comp_clk", comp_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_ones_count", ones_count, 0);
    check("rst_last_decision", last_decision, 0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven bursts
    for (int i = 0; i < NV; i++) begin
      run_vector(i);
    end

    // Continuous mode: re-arm on ack, and ignore a start pulse mid-burst
    continuous   = 1'b1;
    prech_cycles = 8'd2;
    eval_cycles  = 8'd4;
    num_samples  = 16'd2;
    start        = 1'b1;
    tick();
    start = 1'b0;
    run_phases(2, 4, 12, 32'hFFFF_FFFF, -1, errs);
    check("cont_b1_pattern_errs", errs, 0);
    check("cont_b1_result_valid", result_valid, 1);
    check("cont_b1_ones_count", ones_count, 2);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("cont_ack_rv", result_valid, 0);
    check("cont_ack_busy", busy, 1);
    check("cont_ack_ones_cleared", ones_count, 0);
    check("cont_ack_comp_clk", comp_clk, 0);
    run_phases(2, 4, 12, 32'hFFFF_FFFF, 3, errs);
    check("cont_b2_pattern_errs", errs, 0);
    check("cont_b2_result_valid", result_valid, 1);
    check("cont_b2_ones_count", ones_count, 2);
    $display("continuous: second burst ones=%0d rv=%0d", ones_count, result_valid);

    // abort and result_ack together in DONE: abort wins, no restart
    abort      = 1'b1;
    result_ack = 1'b1;
    tick();
    abort      = 1'b0;
    result_ack = 1'b0;
    check("done_abort_busy", busy, 0);
    check("done_abort_rv", result_valid, 0);
    repeat (3) tick();
    check("done_abort_no_restart", busy, 0);
    continuous = 1'b0;
    $display("done abort+ack: busy=%0d rv=%0d", busy, result_valid);

    // Abort during the second EVAL of a 5-sample burst
    prech_cycles = 8'd2;
    eval_cycles  = 8'd4;
    num_samples  = 16'd5;
    start        = 1'b1;
    tick();
    start = 1'b0;
    run_phases(2, 4, 9, 32'hFFFF_FFFF, -1, errs);
    check("abort_pre_pattern_errs", errs, 0);
    abort = 1'b1;
    tick();
    check("abort_comp_clk", comp_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_rv", result_valid, 0);
    check("abort_ones_partial", ones_count, 1);
    check("abort_last_decision", last_decision, 1);
    start = 1'b1;  // ignored while abort is held
    tick();
    start = 1'b0;
    check("abort_blocks_start", busy, 0);
    abort = 1'b0;
    repeat (3) tick();
    check("abort_idle_busy", busy, 0);
    check("abort_idle_rv", result_valid, 0);
    $display("abort: ones=%0d busy=%0d", ones_count, busy);

    // Asynchronous reset mid-EVAL, between clock edges
    start = 1'b1;
    tick();
    start = 1'b0;
    run_phases(2, 4, 9, 32'hFFFF_FFFF, -1, errs);
    check("arst_pre_pattern_errs", errs, 0);
    check("arst_pre_comp_clk", comp_clk, 1);
    check("arst_pre_ones", ones_count, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_comp_clk", comp_clk, 0);
    check("arst_busy", busy, 0);
    check("arst_ones_count", ones_count, 0);
    $display("async reset: comp_clk=%0d busy=%0d ones=%0d", comp_clk, busy, ones_count);
    #3;
    rst = 1'b0;
    tick();
    run_vector(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dyn_comp_sequencer.md
Name: dyn_comp_sequencer

Overview:
- Digital sequencer that drives the clock of the dynamic comparator on io_analog and collects its decisions.
- Runs repeated precharge/evaluate cycles with programmable phase lengths.
- Samples the comparator output through a synchronizer and accumulates a ones-count over a programmed number of decisions.
- Sits in user_analog_proj_example between the LA/Wishbone configuration bits and the comparator's clock and output GPIOs, clocked by wb_clk_i.

Parameters:
- CNT_W, 16, width of the sample counter and ones_count.
- PH_W, 8, width of the phase-length fields.
- SYNC_STAGES, 2, flops in the comp_out synchronizer (legal 2..3).

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle pulse; begins a burst. Accepted only in IDLE.
- abort  input  1  level; forces IDLE.
- continuous  input  1  auto-restart a burst after result_ack.
- prech_cycles  input  PH_W  precharge length in clocks. Latched at start.
- eval_cycles  input  PH_W  evaluate length in clocks. Latched at start.
- num_samples  input  CNT_W  decisions per burst. Latched at start.
- comp_out  input  1  raw comparator decision, asynchronous.
- comp_clk  output  1  comparator clock: 0 = precharge, 1 = evaluate. Registered.
- busy  output  1  high in PRECH, EVAL or DONE.
- result_valid  output  1  high in DONE.
- result_ack  input  1  consumes the result.
- ones_count  output  CNT_W  decisions equal to 1 in the last or current burst.
- last_decision  output  1  most recent sampled decision.

Behaviour:
- Reset (async assert, sync release): state IDLE; comp_clk=0, busy=0, result_valid=0, ones_count=0, last_decision=0; synchronizer flops=0; internal counters=0.
- Config latching: on accepted start, latch Pe=max(prech_cycles,1), Ee=max(eval_cycles,SYNC_STAGES+1), Ne=max(num_samples,1). Clear ones_count and the sample counter.
- IDLE:
  - comp_clk=0.
  - start=1 and abort=0 -> PRECH next cycle.
  - start while not in IDLE is ignored.
- PRECH:
  - comp_clk=0 for exactly Pe cycles, then EVAL.
- EVAL:
  - comp_clk=1 for exactly Ee cycles.
  - On the last EVAL cycle, capture the synchronized comp_out (sync_q): ones_count += sync_q, last_decision <= sync_q, sample counter +1. The updated values are visible the next cycle.
  - If the incremented counter == Ne -> DONE, else PRECH.
  - comp_clk falls on the same edge as the capture.
- DONE:
  - comp_clk=0, result_valid=1; ones_count and last_decision are held.
  - result_ack=1 -> result_valid=0 next cycle, then PRECH with a fresh burst if continuous=1 (same latched config; ones_count cleared), else IDLE.
  - result_ack outside DONE is ignored.
- Period per decision = Pe+Ee clocks. Burst length = Ne*(Pe+Ee) clocks from the start edge to result_valid rising.
- ones_count cannot overflow: bounded by Ne ≤ 2^CNT_W-1.
- abort:
  - Any state -> IDLE on the next edge; comp_clk=0 on that edge.
  - result_valid=0; ones_count and last_decision keep their partial values.
  - abort has priority over start, result_ack and phase transitions.
  - While abort=1, start is ignored.
- Simultaneous result_ack and abort in DONE: abort wins -> IDLE, no restart.
- Changing config inputs mid-burst has no effect until the next accepted start.
- Reset mid-burst: immediate return to reset values; comp_clk low asynchronously.

Test Plan:
- Single burst: reset, prech_cycles=2, eval_cycles=4, num_samples=3, comp_out=1 constant, start pulse -> comp_clk pattern 0,0,1,1,1,1 repeated 3×; result_valid rises 18 cycles after start; ones_count=3; last_decision=1; result_ack -> IDLE, busy=0.
- Clamping: prech_cycles=0, eval_cycles=1, num_samples=0 -> 1 precharge cycle, 3 evaluate cycles, one decision; result_valid after 4 cycles.
- Alternating input: comp_out toggled each decision, starting at 0, num_samples=8 -> ones_count=4, last_decision=1.
- Continuous mode: continuous=1, num_samples=2, comp_out=1; ack the first result -> second burst starts with no further start; ones_count cleared, then 2; a start pulse mid-burst changes nothing.
- Abort: abort during the second EVAL of a 5-sample burst -> comp_clk=0 next cycle; state IDLE; result_valid stays 0; ones_count holds the 1-sample partial value.
- Async reset asserted mid-EVAL, between clock edges -> comp_clk, busy and ones_count go to 0 without a clock edge; after release, a new start works normally.
